io_bus_arbiter: RTL and testbench

//   Shares the 8-bit I/O port bus between two requesters: port 0 = CPU, port 1 = debug loader.

---
 rtl/io_bus_arbiter.sv | 114 +++++++++++
 tb/tb_io_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin arbiter sharing the 8-bit I/O bus between CPU (port 0) and debug loader (port 1).
// Each access runs SETUP -> STROBE -> HOLD. Defining IOARB_WAIT_EN adds the i_ioWaitN wait-state input with timeout.
module io_bus_arbiter #(
    parameter int STROBE_CYCLES = 2
`ifdef IOARB_WAIT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_reqValid,
    input  logic [1:0]  i_reqWrite,
    input  logic [15:0] i_reqAddr,
    input  logic [15:0] i_reqWdata,
    output logic [1:0]  o_reqReady,
    output logic [1:0]  o_respValid,
    output logic [7:0]  o_respRdata,
    output logic        o_respErr,
    output logic        o_ioSelect,
    output logic [7:0]  o_ioAddress,
    output logic        o_ioNOE,
    output logic        o_ioNWE,
    output logic [7:0]  o_bus,
    output logic        o_busNOE,
`ifdef IOARB_WAIT_EN
    input  logic        i_ioWaitN,
`endif
    input  logic [7:0]  i_bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t     state, state_nx;
    logic       prio, gnt_port, port_q, write_q, err_q;
    logic       strobe_last, strobe_done, timed_out, active;
    logic [7:0] addr_q, wdata_q;
    logic [3:0] cnt;

    assign gnt_port    = &i_reqValid ? prio : i_reqValid[1];
    assign strobe_last = state == STROBE && cnt == 4'(STROBE_CYCLES - 1);

`ifdef IOARB_WAIT_EN
    logic [7:0] wcnt;
    assign timed_out   = !i_ioWaitN && wcnt == 8'(TIMEOUT_CYCLES);
    assign strobe_done = strobe_last && (i_ioWaitN || timed_out);

    // count extra STROBE cycles spent waiting past the nominal strobe length
    always_ff @(posedge i_clk)
        if (i_reset) wcnt <= '0;
        else         wcnt <= (strobe_last && !strobe_done) ? wcnt + 8'd1 : '0;
`else
    assign timed_out   = 1'b0;
    assign strobe_done = strobe_last;
`endif

    // state register
    always_ff @(posedge i_clk)
        state <= i_reset ? IDLE : state_nx;

    // next state plus the grant and completion pulses
    always_comb begin
        state_nx    = state;
        o_reqReady  = '0;
        o_respValid = '0;
        case (state)
            IDLE: if (|i_reqValid) begin
                state_nx   = SETUP;
                o_reqReady = i_reset ? 2'b00 : gnt_port ? 2'b10 : 2'b01;
            end
            SETUP:   state_nx = STROBE;
            STROBE:  if (strobe_done) state_nx = HOLD;
            HOLD: begin
                state_nx    = IDLE;
                o_respValid = port_q ? 2'b10 : 2'b01;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign active      = state != IDLE;
    assign o_ioSelect  = active;
    assign o_ioAddress = active ? addr_q : '0;
    assign o_ioNOE     = !(state == STROBE && !write_q);
    assign o_ioNWE     = !(state == STROBE && write_q);
    assign o_busNOE    = !(active && write_q);
    assign o_bus       = (active && write_q) ? wdata_q : '0;
    assign o_respErr   = state == HOLD && err_q;

    // latch granted request, advance round-robin pointer, time the strobe, capture read data
    always_ff @(posedge i_clk)
        if (i_reset) begin
            prio        <= 1'b0;
            port_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt         <= '0;
            err_q       <= 1'b0;
            o_respRdata <= '0;
        end else begin
            if (state == IDLE && |i_reqValid) begin
                port_q  <= gnt_port;
                prio    <= !gnt_port;
                write_q <= i_reqWrite[gnt_port];
                addr_q  <= gnt_port ? i_reqAddr[15:8] : i_reqAddr[7:0];
                wdata_q <= gnt_port ? i_reqWdata[15:8] : i_reqWdata[7:0];
            end
            cnt <= (state == STROBE && !strobe_last) ? cnt + 4'd1 : (strobe_last && !strobe_done) ? cnt : '0;
            if (strobe_done) begin
                err_q <= timed_out;
                if (!write_q) o_respRdata <= timed_out ? 8'hFF : i_bus;
            end
        end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed and randomized checks of io_bus_arbiter against a transaction-level model.
module tb_io_bus_arbiter;
    localparam int S = 2;
`ifdef IOARB_WAIT_EN
    localparam int TO = 4;
    logic i_ioWaitN;
`endif
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [1:0]  i_reqValid, i_reqWrite;
    logic [15:0] i_reqAddr, i_reqWdata;
    logic [7:0]  i_bus;
    logic [1:0]  o_reqReady, o_respValid;
    logic [7:0]  o_respRdata, o_ioAddress, o_bus;
    logic        o_respErr, o_ioSelect, o_ioNOE, o_ioNWE, o_busNOE;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] bus_hist [int];
    int grant_port_log[$];
    int grant_cyc_log[$];

    io_bus_arbiter #(
        .STROBE_CYCLES(S)
`ifdef IOARB_WAIT_EN
        , .TIMEOUT_CYCLES(TO)
`endif
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_reqValid(i_reqValid), .i_reqWrite(i_reqWrite),
        .i_reqAddr(i_reqAddr), .i_reqWdata(i_reqWdata),
        .o_reqReady(o_reqReady), .o_respValid(o_respValid),
        .o_respRdata(o_respRdata), .o_respErr(o_respErr),
        .o_ioSelect(o_ioSelect), .o_ioAddress(o_ioAddress),
        .o_ioNOE(o_ioNOE), .o_ioNWE(o_ioNWE),
        .o_bus(o_bus), .o_busNOE(o_busNOE),
`ifdef IOARB_WAIT_EN
        .i_ioWaitN(i_ioWaitN),
`endif
        .i_bus(i_bus)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        i_reset = 1'b1;
        i_reqValid = '0;
        i_reqWrite = '0;
        i_reqAddr = '0;
        i_reqWdata = '0;
        i_bus = '0;
`ifdef IOARB_WAIT_EN
        i_ioWaitN = 1'b1;
`endif
        step();
        step();
        i_reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [32:0] got;
        do_reset();
        i_reset = 1'b1;
        i_reqValid = 2'b11;
        step();
        @(negedge i_clk);
        got = {o_ioSelect, o_ioAddress, o_ioNOE, o_ioNWE, o_bus, o_busNOE, o_reqReady, o_respValid, o_respRdata, o_respErr};
        checks++;
        if (got !== {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", got, {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00, 1'b0});
        end
        step();
        i_reset = 1'b0;
        i_reqValid = 2'b01;
        i_reqWrite = 2'b01;
        i_reqAddr = 16'h0012;
        i_reqWdata = 16'h00A5;
        @(negedge i_clk);
        checks++;
        if (o_reqReady !== 2'b01) begin
            failures++;
            $display("FAIL reset_abort_grant: got %b expected 01", o_reqReady);
        end
        step();
        i_reqValid = 2'b00;
        step();
        i_reset = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_ioNWE !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_in_strobe: got nwe=%b expected 0", o_ioNWE);
        end
        step();
        i_reset = 1'b0;
        @(negedge i_clk);
        got = {o_ioSelect, o_ioAddress, o_ioNOE, o_ioNWE, o_bus, o_busNOE, o_reqReady, o_respValid, o_respRdata, o_respErr};
        checks++;
        if (got !== {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00, 1'b0}) begin
            failures++;
            $display("FAIL reset_abort_state: got %h expected %h", got, {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 2'b00, 2'b00, 8'h00, 1'b0});
        end
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge i_clk);
            checks++;
            if (o_respValid !== 2'b00 || o_ioSelect !== 1'b0) begin
                failures++;
                $display("FAIL reset_abort_no_resp: got resp=%b sel=%b expected 00/0", o_respValid, o_ioSelect);
            end
        end
    endtask

    task automatic test_read;
        do_reset();
        i_reqValid = 2'b01;
        i_reqWrite = 2'b00;
        i_reqAddr = 16'hEE00;
        i_bus = 8'h5A;
        @(negedge i_clk);
        checks++;
        if (o_reqReady !== 2'b01) begin
            failures++;
            $display("FAIL read_grant: got %b expected 01", o_reqReady);
        end
        for (int d = 1; d <= S + 4; d++) begin
            step();
            i_reqValid = 2'b00;
            i_bus = (d <= S + 1) ? 8'h5A : 8'h00;
            @(negedge i_clk);
            checks++;
            if (o_ioNOE !== !(d >= 2 && d <= S + 1) || o_ioNWE !== 1'b1 || o_ioSelect !== (d <= S + 2)) begin
                failures++;
                $display("FAIL read_strobe d=%0d: got noe=%b nwe=%b sel=%b expected %b/1/%b", d, o_ioNOE, o_ioNWE, o_ioSelect, !(d >= 2 && d <= S + 1), d <= S + 2);
            end
            checks++;
            if (o_respValid !== ((d == S + 2) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL read_resp d=%0d: got %b expected %b", d, o_respValid, (d == S + 2) ? 2'b01 : 2'b00);
            end
            if (d >= S + 2) begin
                checks++;
                if (o_respRdata !== 8'h5A || o_respErr !== 1'b0) begin
                    failures++;
                    $display("FAIL read_rdata d=%0d: got %h err=%b expected 5a err=0", d, o_respRdata, o_respErr);
                end
            end
        end
    endtask

    task automatic test_write;
        do_reset();
        i_reqValid = 2'b10;
        i_reqWrite = 2'b10;
        i_reqAddr = 16'h0077;
        i_reqWdata = 16'hC33C;
        @(negedge i_clk);
        checks++;
        if (o_reqReady !== 2'b10) begin
            failures++;
            $display("FAIL write_grant: got %b expected 10", o_reqReady);
        end
        for (int d = 1; d <= S + 4; d++) begin
            step();
            i_reqValid = 2'b00;
            i_reqWdata = 16'h0000;
            @(negedge i_clk);
            checks++;
            if (o_busNOE !== !(d <= S + 2) || (d <= S + 2 && (o_bus !== 8'hC3 || o_ioAddress !== 8'h00))) begin
                failures++;
                $display("FAIL write_bus d=%0d: got busnoe=%b bus=%h addr=%h expected %b/c3/00", d, o_busNOE, o_bus, o_ioAddress, !(d <= S + 2));
            end
            checks++;
            if (o_ioNWE !== !(d >= 2 && d <= S + 1) || o_ioNOE !== 1'b1) begin
                failures++;
                $display("FAIL write_strobe d=%0d: got nwe=%b noe=%b expected %b/1", d, o_ioNWE, o_ioNOE, !(d >= 2 && d <= S + 1));
            end
            checks++;
            if (o_respValid !== ((d == S + 2) ? 2'b10 : 2'b00)) begin
                failures++;
                $display("FAIL write_resp d=%0d: got %b expected %b", d, o_respValid, (d == S + 2) ? 2'b10 : 2'b00);
            end
        end
    endtask

    // random traffic checked against a per-access timeline model
    task automatic run_traffic(input logic [1:0] en, input int n, input bit ff_addr, input int max_gap);
        int rem[2];
        int gap[2];
        logic [7:0] ra[2];
        logic [7:0] rd[2];
        logic rwr[2];
        int g = -1000;
        int gp = 0;
        logic gw = 1'b0;
        logic [7:0] ga = 8'h00;
        logic [7:0] gwd = 8'h00;
        int next_free, last, budget, win, d;
        logic [7:0] m_rdata = 8'h00;
        logic [1:0] exp_ready, exp_resp;
        logic act, stb;
        do_reset();
        next_free = cyc;
        last = 1;
        budget = 0;
        grant_port_log.delete();
        grant_cyc_log.delete();
        for (int p = 0; p < 2; p++) begin
            rem[p] = en[p] ? n : 0;
            gap[p] = 0;
            ra[p] = ff_addr ? 8'hFF : 8'($urandom);
            rd[p] = 8'($urandom);
            rwr[p] = 1'($urandom);
        end
        while ((rem[0] + rem[1] > 0 || cyc <= g + S + 2) && budget < 2000) begin
            for (int p = 0; p < 2; p++) begin
                i_reqValid[p] = rem[p] > 0 && gap[p] == 0;
                i_reqWrite[p] = rwr[p];
                i_reqAddr[8*p +: 8] = ra[p];
                i_reqWdata[8*p +: 8] = rd[p];
            end
            i_bus = 8'($urandom);
            bus_hist[cyc] = i_bus;
            win = -1;
            if (cyc >= next_free && |i_reqValid)
                win = (&i_reqValid) ? 1 - last : (i_reqValid[1] ? 1 : 0);
            exp_ready = (win < 0) ? 2'b00 : (win == 1) ? 2'b10 : 2'b01;
            d = cyc - g;
            act = d >= 1 && d <= S + 2;
            stb = d >= 2 && d <= S + 1;
            exp_resp = (d != S + 2) ? 2'b00 : (gp == 1) ? 2'b10 : 2'b01;
            if (d == S + 2 && !gw) m_rdata = bus_hist[g + S + 1];
            @(negedge i_clk);
            checks++;
            if (o_reqReady !== exp_ready) begin
                failures++;
                $display("FAIL traffic_grant cyc=%0d: got %b expected %b", cyc, o_reqReady, exp_ready);
            end
            checks++;
            if (o_respValid !== exp_resp || o_respErr !== 1'b0) begin
                failures++;
                $display("FAIL traffic_resp cyc=%0d: got %b err=%b expected %b err=0", cyc, o_respValid, o_respErr, exp_resp);
            end
            checks++;
            if (o_respRdata !== m_rdata) begin
                failures++;
                $display("FAIL traffic_rdata cyc=%0d: got %h expected %h", cyc, o_respRdata, m_rdata);
            end
            checks++;
            if (o_ioSelect !== act || o_ioNOE !== !(stb && !gw) || o_ioNWE !== !(stb && gw) || o_busNOE !== !(act && gw)) begin
                failures++;
                $display("FAIL traffic_ctrl cyc=%0d: got sel=%b noe=%b nwe=%b busnoe=%b expected %b/%b/%b/%b", cyc, o_ioSelect, o_ioNOE, o_ioNWE, o_busNOE, act, !(stb && !gw), !(stb && gw), !(act && gw));
            end
            if (act) begin
                checks++;
                if (o_ioAddress !== ga || (gw && o_bus !== gwd)) begin
                    failures++;
                    $display("FAIL traffic_addr_data cyc=%0d: got addr=%h bus=%h expected %h/%h", cyc, o_ioAddress, o_bus, ga, gwd);
                end
            end
            for (int p = 0; p < 2; p++)
                if (!i_reqValid[p] && gap[p] > 0) gap[p]--;
            if (win >= 0) begin
                g = cyc;
                gp = win;
                gw = rwr[win];
                ga = ra[win];
                gwd = rd[win];
                next_free = cyc + S + 3;
                last = win;
                grant_port_log.push_back(win);
                grant_cyc_log.push_back(cyc);
                rem[win]--;
                gap[win] = $urandom_range(max_gap, 0);
                ra[win] = ff_addr ? 8'hFF : 8'($urandom);
                rd[win] = 8'($urandom);
                rwr[win] = 1'($urandom);
            end
            step();
            budget++;
        end
        i_reqValid = 2'b00;
        checks++;
        if (budget >= 2000) begin
            failures++;
            $display("FAIL traffic_budget: got %0d cycles expected < 2000", budget);
        end
    endtask

    task automatic test_contention;
        run_traffic(2'b11, 4, 1'b0, 0);
        checks++;
        if (grant_port_log.size() != 8) begin
            failures++;
            $display("FAIL contention_count: got %0d expected 8", grant_port_log.size());
        end
        foreach (grant_port_log[i]) begin
            checks++;
            if (grant_port_log[i] != i % 2) begin
                failures++;
                $display("FAIL contention_order[%0d]: got %0d expected %0d", i, grant_port_log[i], i % 2);
            end
        end
    endtask

    task automatic test_single;
        run_traffic(2'b10, 4, 1'b1, 0);
        checks++;
        if (grant_port_log.size() != 4) begin
            failures++;
            $display("FAIL single_count: got %0d expected 4", grant_port_log.size());
        end
        for (int i = 1; i < grant_cyc_log.size(); i++) begin
            checks++;
            if (grant_cyc_log[i] - grant_cyc_log[i-1] != S + 3 || grant_port_log[i] != 1) begin
                failures++;
                $display("FAIL single_period[%0d]: got %0d port %0d expected %0d port 1", i, grant_cyc_log[i] - grant_cyc_log[i-1], grant_port_log[i], S + 3);
            end
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) run_traffic(2'b11, 8, 1'b0, 4);
        run_traffic(2'b01, 6, 1'b0, 2);
    endtask

`ifdef IOARB_WAIT_EN
    task automatic test_timeout;
        do_reset();
        i_ioWaitN = 1'b0;
        i_reqValid = 2'b01;
        i_reqWrite = 2'b00;
        i_reqAddr = 16'h0033;
        i_bus = 8'h12;
        @(negedge i_clk);
        for (int d = 1; d <= S + TO + 3; d++) begin
            step();
            i_reqValid = 2'b00;
            @(negedge i_clk);
            checks++;
            if (o_ioNOE !== !(d >= 2 && d <= S + TO + 1) || o_respValid !== ((d == S + TO + 2) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL timeout_strobe d=%0d: got noe=%b resp=%b expected %b/%b", d, o_ioNOE, o_respValid, !(d >= 2 && d <= S + TO + 1), (d == S + TO + 2) ? 2'b01 : 2'b00);
            end
            if (d == S + TO + 2) begin
                checks++;
                if (o_respErr !== 1'b1 || o_respRdata !== 8'hFF) begin
                    failures++;
                    $display("FAIL timeout_resp: got err=%b rdata=%h expected 1/ff", o_respErr, o_respRdata);
                end
            end
        end
        i_ioWaitN = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_single();
        test_random();
`ifdef IOARB_WAIT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
